// File: rtl/jedec_p.sv
// Shared eMMC/JEDEC protocol definitions: response kinds, frame lengths,
// CRC7 polynomial and default response-timeout budget.
package jedec_p;

  localparam int         FULL_RESPONSE_WIDTH = 128;
  localparam int         R48_FRAME_LEN       = 48;
  localparam int         R136_FRAME_LEN      = 136;
  localparam logic [6:0] CRC7_POLY           = 7'h09;  // x^7 + x^3 + 1
  localparam int         NCR_MAX_DEFAULT     = 64;

  // Response frame kinds expected on the CMD line.
  typedef enum logic [1:0] {
    RESP_NONE      = 2'd0,
    RESP_R48       = 2'd1,  // R1 / R1b
    RESP_R48_NOCRC = 2'd2,  // R3
    RESP_R136      = 2'd3   // R2
  } resp_type_t;

  // Bit-counter value of the final (end) bit of a frame; the start bit is count 0.
  function automatic logic [7:0] last_bit_cnt(input resp_type_t t);
    return (t == RESP_R136) ? 8'(R136_FRAME_LEN - 1) : 8'(R48_FRAME_LEN - 1);
  endfunction

endpackage

// File: rtl/emmc_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first. Shared by the CMD transmitter and
// the response receiver. clr_i has priority over en_i.
module emmc_crc7
  import jedec_p::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);

  logic fb;
  assign fb = din_i ^ crc_o[6];

  // LFSR update: shift left, fold in the polynomial when the feedback bit is set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      crc_o <= '0;
    end else if (clr_i) begin
      crc_o <= '0;
    end else if (en_i) begin
      crc_o <= {crc_o[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/emmc_resp_rx.sv
// eMMC CMD-line response receiver. Armed after a command's end bit, hunts for
// the response start bit, deserialises R1/R1b, R3 or R2 frames, checks frame
// bits and CRC7, and presents a parallel response word.
// Optional build macro: EMMC_RESP_IDX_CHECK_EN -- when defined, an R48 response
// whose index differs from the expected command index raises frame_err_o.
module emmc_resp_rx
  import jedec_p::*;
#(
  parameter int NCR_MAX = NCR_MAX_DEFAULT,
  parameter int RESP_W  = FULL_RESPONSE_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bit_en_i,
  input  logic              cmd_i,
  input  logic              arm_i,
  input  resp_type_t        resp_type_i,
  input  logic [5:0]        exp_idx_i,
  output logic              busy_o,
  output logic              resp_valid_o,
  output logic [5:0]        resp_idx_o,
  output logic [RESP_W-1:0] resp_data_o,
  output logic              crc_err_o,
  output logic              frame_err_o,
  output logic              timeout_o
);

  localparam int NCR_W = $clog2(NCR_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_RECV, S_DONE} state_t;

  state_t           state_q;
  resp_type_t       type_q;
  logic [NCR_W-1:0] ncr_q;
  logic [7:0]       bit_cnt_q;
  logic [133:0]     sr_q;

  logic [134:0] full;   // frame bits so far, including the bit on cmd_i now
  logic         is_r136;
  logic [7:0]   last_cnt;
  logic         arm_accept;
  logic         last_bit;
  logic         crc_clr;
  logic         crc_en;
  logic         idx_err;
  logic [6:0]   crc_q;
  logic [5:0]   rx_idx;
  logic         rx_frame_err;
  logic         rx_crc_err;
  logic [127:0] rx_data;

  assign full       = {sr_q, cmd_i};
  assign is_r136    = (type_q == RESP_R136);
  assign last_cnt   = last_bit_cnt(type_q);
  assign last_bit   = (bit_cnt_q == last_cnt);
  assign arm_accept = (state_q == S_IDLE) && bit_en_i && arm_i && (resp_type_i != RESP_NONE);
  assign crc_clr    = (state_q == S_WAIT_START) && bit_en_i && !cmd_i;
  // CRC covers frame bit positions 47..8 (R48) or 127..8 (R136, header excluded).
  assign crc_en     = (state_q == S_RECV) && bit_en_i &&
                      (bit_cnt_q >= (is_r136 ? 8'd8 : 8'd1)) &&
                      (bit_cnt_q <= last_cnt - 8'd8);

  emmc_crc7 u_crc7 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .din_i  (cmd_i),
    .crc_o  (crc_q)
  );

`ifdef EMMC_RESP_IDX_CHECK_EN
  logic [5:0] exp_idx_q;

  // Capture the expected command index when a response is armed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_idx_q <= '0;
    end else if (arm_accept) begin
      exp_idx_q <= exp_idx_i;
    end
  end

  assign idx_err = (type_q == RESP_R48) && (rx_idx != exp_idx_q);
`else
  logic unused_exp_idx;
  assign unused_exp_idx = ^exp_idx_i;
  assign idx_err        = 1'b0;
`endif

  // Evaluate the completed frame as the end bit arrives on cmd_i.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    rx_idx       = is_r136 ? full[133:128] : full[45:40];
    rx_frame_err = (is_r136 ? full[134] : full[46]) | ~full[0];
    rx_crc_err   = 1'b0;
    rx_data      = is_r136 ? {full[127:1], 1'b0} : {96'b0, full[39:8]};
    if ((type_q != RESP_R48) && (rx_idx != 6'h3F)) begin
      rx_frame_err = 1'b1;
    end
    if (type_q == RESP_R48_NOCRC) begin
      if (full[7:1] != 7'h7F) begin
        rx_frame_err = 1'b1;
      end
    end else begin
      rx_crc_err = (full[7:1] != crc_q);
    end
    rx_frame_err = rx_frame_err | idx_err;
  end

  // Receiver FSM with registered result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      type_q       <= RESP_NONE;
      ncr_q        <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      busy_o       <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_idx_o   <= '0;
      resp_data_o  <= '0;
      crc_err_o    <= 1'b0;
      frame_err_o  <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_o <= 1'b0;
          if (arm_accept) begin
            state_q     <= S_WAIT_START;
            type_q      <= resp_type_i;
            ncr_q       <= '0;
            busy_o      <= 1'b1;
            resp_idx_o  <= '0;
            resp_data_o <= '0;
            crc_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
            timeout_o   <= 1'b0;
          end
        end
        S_WAIT_START: begin
          if (bit_en_i) begin
            if (!cmd_i) begin
              state_q   <= S_RECV;
              bit_cnt_q <= 8'd1;
              sr_q      <= '0;
            end else if (ncr_q == NCR_W'(NCR_MAX - 1)) begin
              state_q      <= S_DONE;
              busy_o       <= 1'b0;
              resp_valid_o <= 1'b1;
              timeout_o    <= 1'b1;
              resp_data_o  <= '0;
            end else begin
              ncr_q <= ncr_q + 1'b1;
            end
          end
        end
        S_RECV: begin
          if (bit_en_i) begin
            sr_q <= full[133:0];
            if (bit_cnt_q != 8'hFF) begin
              bit_cnt_q <= bit_cnt_q + 8'd1;
            end
            if (last_bit) begin
              state_q      <= S_DONE;
              busy_o       <= 1'b0;
              resp_valid_o <= 1'b1;
              resp_idx_o   <= rx_idx;
              resp_data_o  <= RESP_W'(rx_data);
              crc_err_o    <= rx_crc_err;
              frame_err_o  <= rx_frame_err;
            end
          end
        end
        S_DONE: begin
          resp_valid_o <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emmc_resp_rx.sv
// Self-checking bench for emmc_resp_rx: scoreboard of expected responses,
// popped whenever the receiver pulses resp_valid_o.
module tb_emmc_resp_rx;
  import jedec_p::*;

  typedef struct {
    logic [127:0] data;
    logic [5:0]   idx;
    logic         crc;
    logic         frame;
    logic         to;
  } exp_t;

`ifdef EMMC_RESP_IDX_CHECK_EN
  localparam logic IDX_CHECK = 1'b1;
`else
  localparam logic IDX_CHECK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bit_en = 1'b0;
  logic         cmd = 1'b1;
  logic         arm = 1'b0;
  resp_type_t   rtype = RESP_NONE;
  logic [5:0]   exp_idx = '0;
  logic         busy, resp_valid, crc_err, frame_err, timeout;
  logic [5:0]   resp_idx;
  logic [127:0] resp_data;

  int   checks = 0;
  int   failures = 0;
  int   div = 1;
  int   busy_low = 0;
  bit   watch_busy = 1'b0;
  exp_t sb[$];

  emmc_resp_rx #(.NCR_MAX(64), .RESP_W(128)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bit_en_i     (bit_en),
    .cmd_i        (cmd),
    .arm_i        (arm),
    .resp_type_i  (rtype),
    .exp_idx_i    (exp_idx),
    .busy_o       (busy),
    .resp_valid_o (resp_valid),
    .resp_idx_o   (resp_idx),
    .resp_data_o  (resp_data),
    .crc_err_o    (crc_err),
    .frame_err_o  (frame_err),
    .timeout_o    (timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: compare every result pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (watch_busy && !busy) busy_low++;
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_valid got=1 exp=0 (idx=%h data=%h)", resp_idx, resp_data);
      end else begin
        e = sb.pop_front();
        checks += 5;
        if (resp_data !== e.data) begin failures++; $display("FAIL sb_data got=%h exp=%h", resp_data, e.data); end
        if (resp_idx !== e.idx) begin failures++; $display("FAIL sb_idx got=%h exp=%h", resp_idx, e.idx); end
        if (crc_err !== e.crc) begin failures++; $display("FAIL sb_crc_err got=%b exp=%b", crc_err, e.crc); end
        if (frame_err !== e.frame) begin failures++; $display("FAIL sb_frame_err got=%b exp=%b", frame_err, e.frame); end
        if (timeout !== e.to) begin failures++; $display("FAIL sb_timeout got=%b exp=%b", timeout, e.to); end
      end
    end
  end

  // Reference CRC7: bits n-1..0 of 'bits', MSB first.
  function automatic logic [6:0] crc7_model(input logic [127:0] bits, input int n);
    logic [6:0] c = '0;
    logic fb;
    for (int i = n - 1; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] r48_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b00, idx, arg};
    return {88'b0, h, crc7_model({88'b0, h}, 40), 1'b1};
  endfunction

  function automatic exp_t mk_exp(input logic [127:0] d, input logic [5:0] i,
                                  input logic c, input logic f, input logic t);
    exp_t e;
    e.data = d; e.idx = i; e.crc = c; e.frame = f; e.to = t;
    return e;
  endfunction

  // One bit-time: div-1 idle clocks then a strobe cycle carrying b (and optional arm).
  task automatic drive_strobe(input logic b, input logic a);
    for (int i = 0; i < div; i++) begin
      @(negedge clk);
      bit_en = (i == div - 1);
      arm    = a && (i == div - 1);
      cmd    = b;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bit_en = 1'b0;
    arm    = 1'b0;
  endtask

  task automatic send_bits(input logic [135:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) drive_strobe(f[i], 1'b0);
  endtask

  task automatic arm_type(input resp_type_t t, input logic [5:0] idx);
    rtype   = t;
    exp_idx = idx;
    drive_strobe(1'b1, 1'b1);
    drive_strobe(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, resp_valid, resp_idx, resp_data, crc_err, frame_err, timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b v=%b idx=%h data=%h c=%b f=%b t=%b exp=all0",
               busy, resp_valid, resp_idx, resp_data, crc_err, frame_err, timeout);
    end
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_r1();
    logic [135:0] f;
    div = 1;
    arm_type(RESP_R48, 6'd17);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL r1_busy_armed got=%b exp=1", busy); end
    f = r48_frame(6'd17, 32'h0000_0900);
    sb.push_back(mk_exp(128'h900, 6'd17, 1'b0, 1'b0, 1'b0));
    send_bits(f, 47, 1);
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL r1_valid_early got=%b exp=0", resp_valid); end
    drive_strobe(f[0], 1'b0);
    idle_cycle();
    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL r1_valid_latency got=%b exp=1", resp_valid); end
    idle_cycle();
    checks++;
    if ({resp_valid, busy} !== 2'b00) begin failures++; $display("FAIL r1_valid_pulse got=%b%b exp=00", resp_valid, busy); end
    repeat (3) idle_cycle();
    checks++;
    if (resp_data !== 128'h900) begin failures++; $display("FAIL r1_hold got=%h exp=900", resp_data); end

    // Flip the argument LSB while keeping the original CRC field.
    f[8] = ~f[8];
    arm_type(RESP_R48, 6'd17);
    sb.push_back(mk_exp(128'h901, 6'd17, 1'b1, 1'b0, 1'b0));
    send_bits(f, 47, 0);
    idle_cycle();
    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL r1_crc_valid got=%b exp=1", resp_valid); end
    idle_cycle();
  endtask

  task automatic test_r3();
    logic [135:0] f;
    div = 1;
    f = {88'b0, 2'b00, 6'h3F, 32'hC0FF_8080, 7'h7F, 1'b1};
    arm_type(RESP_R48_NOCRC, 6'd1);
    sb.push_back(mk_exp(128'hC0FF_8080, 6'h3F, 1'b0, 1'b0, 1'b0));
    send_bits(f, 47, 0);
    idle_cycle();
    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL r3_valid got=%b exp=1", resp_valid); end
    idle_cycle();
    f[0] = 1'b0;
    arm_type(RESP_R48_NOCRC, 6'd1);
    sb.push_back(mk_exp(128'hC0FF_8080, 6'h3F, 1'b0, 1'b1, 1'b0));
    send_bits(f, 47, 0);
    repeat (3) idle_cycle();
  endtask

  task automatic test_r2();
    logic [127:0] rnd;
    logic [119:0] cid;
    logic [135:0] f;
    div = 4;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    cid = rnd[119:0];
    f   = {2'b00, 6'h3F, cid, crc7_model({8'b0, cid}, 120), 1'b1};
    arm_type(RESP_R136, 6'd2);
    sb.push_back(mk_exp({f[127:1], 1'b0}, 6'h3F, 1'b0, 1'b0, 1'b0));
    busy_low   = 0;
    watch_busy = 1'b1;
    send_bits(f, 135, 0);
    watch_busy = 1'b0;
    checks++;
    if (busy_low !== 0) begin failures++; $display("FAIL r2_busy_low_cycles got=%0d exp=0", busy_low); end
    idle_cycle();
    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL r2_valid got=%b exp=1", resp_valid); end
    idle_cycle();
  endtask

  task automatic test_timeout();
    div = 1;
    rtype = RESP_R48;
    drive_strobe(1'b1, 1'b1);
    sb.push_back(mk_exp(128'h0, 6'h0, 1'b0, 1'b0, 1'b1));
    repeat (63) drive_strobe(1'b1, 1'b0);
    idle_cycle();
    checks++;
    if ({resp_valid, busy} !== 2'b01) begin failures++; $display("FAIL to_before_64 got=%b%b exp=01", resp_valid, busy); end
    drive_strobe(1'b1, 1'b0);
    idle_cycle();
    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL to_on_64 got=%b exp=1", resp_valid); end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    logic [135:0] f;
    div = 1;
    f = {2'b00, 6'h3F, 120'h0123_4567_89AB_CDEF_0011_2233_4455, 7'h55, 1'b1};
    arm_type(RESP_R136, 6'd2);
    send_bits(f, 135, 76);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    @(negedge clk);
    bit_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if ({busy, resp_valid, resp_idx, resp_data, crc_err, frame_err, timeout} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got busy=%b v=%b idx=%h c=%b f=%b t=%b exp=all0",
               busy, resp_valid, resp_idx, crc_err, frame_err, timeout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_bits(f, 75, 0);
    idle_cycle();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_idx();
    logic [135:0] f;
    div = 1;
    f = r48_frame(6'd12, 32'h1234_5678);
    arm_type(RESP_R48, 6'd13);
    sb.push_back(mk_exp(128'h1234_5678, 6'd12, 1'b0, IDX_CHECK, 1'b0));
    send_bits(f, 47, 0);
    repeat (2) idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [135:0] f;
    logic [135:0] g;
    div = 1;
    rtype = RESP_NONE;
    drive_strobe(1'b1, 1'b1);
    idle_cycle();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL arm_none_busy got=%b exp=0", busy); end
    f = r48_frame(6'd5, 32'hDEAD_BEEF);
    g = r48_frame(6'd7, 32'h0000_0001);
    arm_type(RESP_R48, 6'd5);
    sb.push_back(mk_exp(128'hDEAD_BEEF, 6'd5, 1'b0, 1'b0, 1'b0));
    send_bits(f, 47, 28);
    rtype = RESP_R136;            // re-arm attempt mid-frame must be ignored
    drive_strobe(f[27], 1'b1);
    send_bits(f, 26, 0);
    idle_cycle();
    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", resp_valid); end
    rtype   = RESP_R48;
    exp_idx = 6'd7;
    drive_strobe(1'b1, 1'b1);
    sb.push_back(mk_exp(128'h1, 6'd7, 1'b0, 1'b0, 1'b0));
    send_bits(g, 47, 0);
    idle_cycle();
    checks++;
    if (resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", resp_valid); end
    repeat (2) idle_cycle();
  endtask

  initial begin
    test_reset();
    test_r1();
    test_r3();
    test_r2();
    test_timeout();
    test_reset_mid();
    test_idx();
    test_back_to_back();
    repeat (4) idle_cycle();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d pending exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
